// File: rtl/rf_ctrl_pkg.sv
// Shared constants for the register-file write-side control logic.
package rf_ctrl_pkg;

    localparam int unsigned RF_AW   = 5;
    localparam int unsigned RF_DW   = 32;
    localparam int unsigned RF_NREQ = 2;
    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_MEM = 1;

    localparam logic [RF_AW-1:0] R0 = 5'd0;

endpackage

// File: rtl/rf_wr_slot.sv
// One-entry holding register for a pending register-file write.
// Load takes priority over clear so a drained slot can refill on the same edge.
module rf_wr_slot #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          clear,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    output logic          full,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    logic          full_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (load) begin
            full_q <= 1'b1;
            addr_q <= load_addr;
            data_q <= load_data;
        end else if (clear) begin
            full_q <= 1'b0;
        end
    end

    assign full = full_q;
    assign addr = addr_q;
    assign data = data_q;

endmodule

// File: rtl/rf_wr_arbiter.sv
// Arbitrates the single regfile write port between the ALU and load writeback slots, oldest first.
// Define RF_BYPASS_EN to add read-side bypass ports that forward pending slot data.
module rf_wr_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned DW = RF_DW,
    parameter int unsigned AW = RF_AW
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Req0Vld,
    output logic          Req0Rdy,
    input  logic [AW-1:0] Req0Addr,
    input  logic [DW-1:0] Req0Data,
    input  logic          Req1Vld,
    output logic          Req1Rdy,
    input  logic [AW-1:0] Req1Addr,
    input  logic [DW-1:0] Req1Data,
    output logic          WrEn,
    output logic [AW-1:0] Awr,
    output logic [DW-1:0] Din,
    output logic          Busy
`ifdef RF_BYPASS_EN
    ,
    input  logic [AW-1:0] Ard1,
    input  logic [AW-1:0] Ard2,
    output logic          Byp1Hit,
    output logic          Byp2Hit,
    output logic [DW-1:0] Byp1Data,
    output logic [DW-1:0] Byp2Data
`endif
);

    logic [RF_NREQ-1:0] full, grant, rdy, accept;
    logic [AW-1:0]      slot_addr [RF_NREQ];
    logic [DW-1:0]      slot_data [RF_NREQ];
    logic               older1_q, older1_d;

    rf_wr_slot #(.AW(AW), .DW(DW)) u_slot_alu (
        .clk       (Clk),
        .reset     (Reset),
        .load      (accept[REQ_ALU]),
        .clear     (grant[REQ_ALU]),
        .load_addr (Req0Addr),
        .load_data (Req0Data),
        .full      (full[REQ_ALU]),
        .addr      (slot_addr[REQ_ALU]),
        .data      (slot_data[REQ_ALU])
    );

    rf_wr_slot #(.AW(AW), .DW(DW)) u_slot_mem (
        .clk       (Clk),
        .reset     (Reset),
        .load      (accept[REQ_MEM]),
        .clear     (grant[REQ_MEM]),
        .load_addr (Req1Addr),
        .load_data (Req1Data),
        .full      (full[REQ_MEM]),
        .addr      (slot_addr[REQ_MEM]),
        .data      (slot_data[REQ_MEM])
    );

    always_comb begin
        grant[0] = full[0] & (~full[1] | ~older1_q);
        grant[1] = full[1] & (~full[0] | older1_q);
        rdy      = ~full | grant;
        accept   = {Req1Vld, Req0Vld} & rdy;
        // Slot 1 becomes older only when slot 0 loads behind a slot 1 that stays pending;
        // simultaneous loads leave slot 0 the winner.
        older1_d = accept[0] & full[1] & ~grant[1];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            older1_q <= 1'b0;
        end else begin
            older1_q <= older1_d;
        end
    end

    always_comb begin
        Awr = '0;
        Din = '0;
        unique case (grant)
            2'b01: begin
                Awr = slot_addr[0];
                Din = slot_data[0];
            end
            2'b10: begin
                Awr = slot_addr[1];
                Din = slot_data[1];
            end
            default: ;
        endcase
    end

    // r0 writes are consumed silently; reset suppresses a write still being presented.
    assign WrEn    = (Awr != AW'(R0)) & ~Reset;
    assign Busy    = |full;
    assign Req0Rdy = rdy[0];
    assign Req1Rdy = rdy[1];

`ifdef RF_BYPASS_EN
    logic [1:0] match1, match2;

    function automatic logic [DW-1:0] byp_pick(input logic [1:0] m, input logic older1,
                                               input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        if (m == 2'b11) begin
            return older1 ? d0 : d1;
        end else if (m[0]) begin
            return d0;
        end else if (m[1]) begin
            return d1;
        end
        return '0;
    endfunction

    always_comb begin
        match1[0] = full[0] & (slot_addr[0] == Ard1) & (Ard1 != AW'(R0));
        match1[1] = full[1] & (slot_addr[1] == Ard1) & (Ard1 != AW'(R0));
        match2[0] = full[0] & (slot_addr[0] == Ard2) & (Ard2 != AW'(R0));
        match2[1] = full[1] & (slot_addr[1] == Ard2) & (Ard2 != AW'(R0));
    end

    assign Byp1Hit  = |match1;
    assign Byp2Hit  = |match2;
    assign Byp1Data = byp_pick(match1, older1_q, slot_data[0], slot_data[1]);
    assign Byp2Data = byp_pick(match2, older1_q, slot_data[0], slot_data[1]);
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboard bench for rf_wr_arbiter: expected writes are queued at stimulus time and
// popped by a monitor on every presented write. Covers RF_BYPASS_EN when defined.
module tb_rf_wr_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Req0Vld, Req1Vld;
    logic          Req0Rdy, Req1Rdy;
    logic [AW-1:0] Req0Addr, Req1Addr;
    logic [DW-1:0] Req0Data, Req1Data;
    logic          WrEn;
    logic [AW-1:0] Awr;
    logic [DW-1:0] Din;
    logic          Busy;
`ifdef RF_BYPASS_EN
    logic [AW-1:0] Ard1, Ard2;
    logic          Byp1Hit, Byp2Hit;
    logic [DW-1:0] Byp1Data, Byp2Data;
`endif

    int checks = 0;
    int errors = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_exp;

    always #5 Clk = ~Clk;

    rf_wr_arbiter #(.DW(DW), .AW(AW)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Req0Vld  (Req0Vld),
        .Req0Rdy  (Req0Rdy),
        .Req0Addr (Req0Addr),
        .Req0Data (Req0Data),
        .Req1Vld  (Req1Vld),
        .Req1Rdy  (Req1Rdy),
        .Req1Addr (Req1Addr),
        .Req1Data (Req1Data),
        .WrEn     (WrEn),
        .Awr      (Awr),
        .Din      (Din),
        .Busy     (Busy)
`ifdef RF_BYPASS_EN
        ,
        .Ard1     (Ard1),
        .Ard2     (Ard2),
        .Byp1Hit  (Byp1Hit),
        .Byp2Hit  (Byp2Hit),
        .Byp1Data (Byp1Data),
        .Byp2Data (Byp2Data)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    // Monitor: every presented write must match the head of the scoreboard.
    always @(negedge Clk) begin
        if (WrEn === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got Awr=%0d Din=%0h expected no write", Awr, Din);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({Awr, Din} !== mon_exp) begin
                    errors++;
                    $display("FAIL write_order: got Awr=%0d Din=%0h expected Awr=%0d Din=%0h",
                             Awr, Din, mon_exp[AW+DW-1:DW], mon_exp[DW-1:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int i0, i1;
        logic a0, a1;
        Reset = 1'b1;
        Req0Vld = 1'b0; Req0Addr = '0; Req0Data = '0;
        Req1Vld = 1'b0; Req1Addr = '0; Req1Data = '0;
`ifdef RF_BYPASS_EN
        Ard1 = '0; Ard2 = '0;
`endif
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        #2;
        chk("reset_wren", 64'(WrEn), 64'd0);
        chk("reset_busy", 64'(Busy), 64'd0);
        chk("reset_rdy0", 64'(Req0Rdy), 64'd1);
        chk("reset_rdy1", 64'(Req1Rdy), 64'd1);
        chk("reset_awr", 64'(Awr), 64'd0);
        chk("reset_din", 64'(Din), 64'd0);

        // Single ALU write, visible the cycle after acceptance.
        Req0Vld = 1'b1; Req0Addr = 5'd5; Req0Data = 32'hA5A5A5A5;
        exp_q.push_back({5'd5, 32'hA5A5A5A5});
        cyc();
        Req0Vld = 1'b0;
        #2;
        chk("t1_wren", 64'(WrEn), 64'd1);
        chk("t1_busy", 64'(Busy), 64'd1);
        cyc();
        #2;
        chk("t1_busy_clear", 64'(Busy), 64'd0);
        chk("t1_idle_awr", 64'(Awr), 64'd0);
        chk("t1_idle_din", 64'(Din), 64'd0);

        // Same-edge tie: ALU first, then load, both to r3.
        Req0Vld = 1'b1; Req0Addr = 5'd3; Req0Data = 32'd1;
        Req1Vld = 1'b1; Req1Addr = 5'd3; Req1Data = 32'd2;
        exp_q.push_back({5'd3, 32'd1});
        exp_q.push_back({5'd3, 32'd2});
        cyc();
        Req0Vld = 1'b0; Req1Vld = 1'b0;
        #2;
        chk("t2_din_first", 64'(Din), 64'd1);
        chk("t2_rdy1_blocked", 64'(Req1Rdy), 64'd0);
        cyc();
        #2;
        chk("t2_din_second", 64'(Din), 64'd2);
        cyc();

        // Age order: load slot stays pending while ALU slot drains and refills.
        Req0Vld = 1'b1; Req0Addr = 5'd9; Req0Data = 32'h33;
        Req1Vld = 1'b1; Req1Addr = 5'd7; Req1Data = 32'h11;
        exp_q.push_back({5'd9, 32'h33});
        exp_q.push_back({5'd7, 32'h11});
        exp_q.push_back({5'd8, 32'h22});
        cyc();
        Req1Vld = 1'b0; Req0Addr = 5'd8; Req0Data = 32'h22;
        #2;
        chk("t3_rdy0_refill", 64'(Req0Rdy), 64'd1);
        cyc();
        Req0Vld = 1'b0;
        #2;
        chk("t3_older_first", 64'(Awr), 64'd7);
        chk("t3_rdy0_wait", 64'(Req0Rdy), 64'd0);
        cyc();
        #2;
        chk("t3_younger_next", 64'(Awr), 64'd8);
        cyc();

        // r0 write is consumed without WrEn.
        Req0Vld = 1'b1; Req0Addr = 5'd0; Req0Data = 32'hFFFF;
        cyc();
        Req0Vld = 1'b0;
        #2;
        chk("t4_r0_wren", 64'(WrEn), 64'd0);
        chk("t4_r0_busy", 64'(Busy), 64'd1);
        chk("t4_r0_din", 64'(Din), 64'h0000FFFF);
        cyc();
        #2;
        chk("t4_r0_cleared", 64'(Busy), 64'd0);

        // Streaming: both sources hold Vld for 10 cycles; writes alternate by age.
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back({5'(10 + k), 32'(32'h100 + k)});
            if (k < 5) exp_q.push_back({5'(20 + k), 32'(32'h200 + k)});
        end
        i0 = 0;
        i1 = 0;
        for (int j = 0; j < 10; j++) begin
            Req0Vld = 1'b1; Req0Addr = 5'(10 + i0); Req0Data = 32'(32'h100 + i0);
            Req1Vld = 1'b1; Req1Addr = 5'(20 + i1); Req1Data = 32'(32'h200 + i1);
            #2;
            if (j > 0) begin
                chk("t5_rdy0", 64'(Req0Rdy), 64'(j % 2 == 1));
                chk("t5_rdy1", 64'(Req1Rdy), 64'(j % 2 == 0));
                chk("t5_wren", 64'(WrEn), 64'd1);
            end
            a0 = Req0Rdy;
            a1 = Req1Rdy;
            cyc();
            if (a0) i0++;
            if (a1) i1++;
        end
        Req0Vld = 1'b0; Req1Vld = 1'b0;
        chk("t5_alu_accepts", 64'(i0), 64'd6);
        chk("t5_mem_accepts", 64'(i1), 64'd5);
        for (int w = 0; w < 20 && exp_q.size() != 0; w++) cyc();
        chk("t5_drained", 64'(exp_q.size()), 64'd0);
        cyc();

        // Pending r4 write, then reset mid-drain: must never reach the regfile.
        Req0Vld = 1'b1; Req0Addr = 5'd4; Req0Data = 32'h55;
        cyc();
        Req0Vld = 1'b0;
`ifdef RF_BYPASS_EN
        Ard1 = 5'd4; Ard2 = 5'd0;
        #1;
        chk("t6_byp1_hit", 64'(Byp1Hit), 64'd1);
        chk("t6_byp1_data", 64'(Byp1Data), 64'h55);
        chk("t6_byp2_hit", 64'(Byp2Hit), 64'd0);
        chk("t6_byp2_data", 64'(Byp2Data), 64'd0);
`endif
        chk("t6_busy", 64'(Busy), 64'd1);
        Reset = 1'b1;
        #1;
        chk("t6_reset_wren", 64'(WrEn), 64'd0);
        cyc();
        Reset = 1'b0;
        #2;
        chk("t6_reset_busy", 64'(Busy), 64'd0);
        chk("t6_reset_rdy0", 64'(Req0Rdy), 64'd1);
        repeat (3) cyc();
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
